// File: rtl/stream_in_buffer.sv
// First-word-fall-through valid/ready buffer in front of a stream consumer.
// It reports occupancy, a delivered-beat counter and a sticky upstream protocol-error flag.
module stream_in_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [CNT_WIDTH-1:0]         beat_count,
  output logic                         proto_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level_next;
  logic                  push;
  logic                  pop;
  logic                  stalled_q;
  logic [DATA_WIDTH-1:0] stalled_data_q;

  // A push and a pop are each decided only by the handshake seen at the edge.
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign m_valid = (level != '0);
  // Empty buffer shows zero instead of stale or never-written storage.
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LVL_W'(1);
      2'b01:   level_next = level - LVL_W'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // s_ready is registered from the next occupancy, so a pop while full only
  // reopens the input on the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      s_ready    <= 1'b0;
      beat_count <= '0;
    end else begin
      level   <= level_next;
      s_ready <= (level_next < LVL_W'(DEPTH));
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        beat_count <= beat_count + CNT_WIDTH'(1);
      end
    end
  end

  // An offered-but-stalled word must stay offered and unchanged next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stalled_q      <= 1'b0;
      stalled_data_q <= '0;
      proto_err      <= 1'b0;
    end else begin
      stalled_q      <= s_valid && !s_ready;
      stalled_data_q <= s_data;
      if (stalled_q && (!s_valid || (s_data != stalled_data_q))) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_in_buffer.sv
// Directed bench for stream_in_buffer: hand-computed checks plus an in-order
// scoreboard of accepted words against delivered words.
module tb_stream_in_buffer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [2:0] level;
  logic [15:0] beat_count;
  logic       proto_err;

  logic       s_ready_b;
  logic       m_valid_b;
  logic [7:0] m_data_b;
  logic [2:0] level_b;
  logic [3:0] beat_count_b;
  logic       proto_err_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  stream_in_buffer #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level), .beat_count(beat_count), .proto_err(proto_err)
  );

  // Same stimulus, narrow counter, for the wrap check.
  stream_in_buffer #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(4)) dut_narrow (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
    .level(level_b), .beat_count(beat_count_b), .proto_err(proto_err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: handshakes are scored at the negedge, then return #1 after posedge.
  task automatic step();
    @(negedge clk);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) check("sb_pop_empty", 32'(exp_q.size()), 32'd1);
      else check("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
    if (s_valid && s_ready) exp_q.push_back(s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 20) begin
      step();
      n++;
    end
    if (!s_ready) check("send_timeout", 32'(s_ready), 32'd1);
    step();
  endtask

  task automatic drain();
    int n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (level != 3'd0 && n < 20) begin
      step();
      n++;
    end
    check("drain_level", 32'(level), 32'd0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    #3;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_beat", 32'(beat_count), 32'd0);
    check("rst_proto", 32'(proto_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("ready_before_edge", 32'(s_ready), 32'd0);
    step();
    check("ready_after_release", 32'(s_ready), 32'd1);

    // Back-to-back pushes with the consumer always ready.
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h11;
    step();
    check("t1_m_valid", 32'(m_valid), 32'd1);
    check("t1_data0", 32'(m_data), 32'h11);
    check("t1_level1", 32'(level), 32'd1);
    s_data = 8'h22;
    step();
    check("t1_data1", 32'(m_data), 32'h22);
    s_data = 8'h33;
    step();
    check("t1_data2", 32'(m_data), 32'h33);
    check("t1_level_hold", 32'(level), 32'd1);
    s_valid = 1'b0;
    step();
    check("t1_beat", 32'(beat_count), 32'd3);
    check("t1_level0", 32'(level), 32'd0);
    check("t1_empty", 32'(m_valid), 32'd0);

    // Fill while stalled; A4 stays offered until the first pop frees a slot.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
    s_data = 8'hA4;
    check("t2_full_ready", 32'(s_ready), 32'd0);
    check("t2_full_level", 32'(level), 32'd4);
    step();
    step();
    check("t2_stall_ready", 32'(s_ready), 32'd0);
    check("t2_stall_data", 32'(m_data), 32'hA0);
    check("t2_stall_level", 32'(level), 32'd4);
    m_ready = 1'b1;
    step();
    check("t3_pop_only_level", 32'(level), 32'd3);
    check("t3_ready_back", 32'(s_ready), 32'd1);
    check("t3_head", 32'(m_data), 32'hA1);
    step();
    check("t3_accept_level", 32'(level), 32'd3);
    s_data = 8'hA5;
    step();
    drain();
    check("t2_beat", 32'(beat_count), 32'd9);
    check("t2_proto", 32'(proto_err), 32'd0);

    // Steady state at two words: output lags input by two beats.
    m_ready = 1'b0;
    send(8'hB0);
    send(8'hB1);
    check("t4_level_start", 32'(level), 32'd2);
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'hB2 + 8'(i);
      step();
      check("t4_level", 32'(level), 32'd2);
      check("t4_head", 32'(m_data), 32'(8'hB1 + 8'(i)));
    end
    drain();
    check("t4_beat", 32'(beat_count), 32'd21);

    // Upstream withdraws a stalled word.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i));
    s_data = 8'hC4;
    step();
    check("t5_proto_before", 32'(proto_err), 32'd0);
    s_valid = 1'b0;
    step();
    check("t5_proto_set", 32'(proto_err), 32'd1);
    drain();
    check("t5_proto_sticky", 32'(proto_err), 32'd1);
    check("t5_beat", 32'(beat_count), 32'd25);

    // Asynchronous reset with three words stored.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'hD0 + 8'(i));
    s_valid = 1'b0;
    check("t6_level_pre", 32'(level), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_m_valid", 32'(m_valid), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_beat", 32'(beat_count), 32'd0);
    check("t6_proto", 32'(proto_err), 32'd0);
    check("t6_s_ready", 32'(s_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    check("t6_ready_again", 32'(s_ready), 32'd1);
    m_ready = 1'b1;
    send(8'hE0);
    check("t6_first_word", 32'(m_data), 32'hE0);

    // Seventeen deliveries: a 4-bit counter wraps to 1.
    for (int i = 1; i < 17; i++) send(8'hE0 + 8'(i));
    drain();
    check("t7_beat_wide", 32'(beat_count), 32'd17);
    check("t7_beat_narrow", 32'(beat_count_b), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
